// File: rtl/manchester_uart_rx_if.sv
// Valid/ready bundle carrying recovered words out of the Manchester receiver.
// master: drives rx_data/rx_valid, samples rx_ready. slave: the consumer side.
interface manchester_uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/manchester_uart_rx.sv
// Manchester-coded UART receiver: oversamples rx, rebuilds a DATA_BITS word
// from two half-frames (MSB half first) and offers it on a valid/ready port.
// Ports: clk, reset (sync, active high), rx (async line), rx_if (master:
// rx_data/rx_valid out, rx_ready in), rx_error and rx_overrun (1-cycle pulses).
module manchester_uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int BAUDRATE  = 115200,
    parameter int CLK_FREQ  = 18_750_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    manchester_uart_rx_if.master        rx_if,
    output logic                        rx_error,
    output logic                        rx_overrun
);

    localparam int NB        = DATA_BITS / 2;
    localparam int FULLBAUD  = CLK_FREQ / BAUDRATE;
    localparam int HALFBAUD  = FULLBAUD / 2;
    localparam int QUARTBAUD = FULLBAUD / 4;

    localparam logic [31:0] START_MIN = 32'(3 * QUARTBAUD);
    localparam logic [31:0] FIRST_LIM = 32'(HALFBAUD + QUARTBAUD - 1);
    localparam logic [31:0] NEXT_LIM  = 32'(HALFBAUD - 1);
    localparam logic [31:0] GAP_LIM   = 32'(4 * FULLBAUD - 1);
    localparam logic [31:0] HI_MAX    = 32'hFFFF_FFFF;
    localparam logic [3:0]  LAST_BIT  = 4'(NB - 1);

    typedef enum logic [2:0] {
        HUNT,
        SAMPLE,
        STOP,
        GAP,
        DELIVER
    } state_e;

    state_e               state_q, state_d;
    logic                 sync_q;
    logic                 rxs_q;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          ph_q, ph_d;
    logic [31:0]          tmo_q, tmo_d;
    logic                 first_q, first_d;
    logic                 chipb_q, chipb_d;
    logic                 chipa_q, chipa_d;
    logic                 half_q, half_d;
    logic [3:0]           bits_q, bits_d;
    logic [NB-1:0]        shreg_q, shreg_d;
    logic [NB-1:0]        msb_q, msb_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 ovr_q, ovr_d;

    logic                 start_det;
    logic                 sample_pt;

    // Length of the current high run on rxs, saturating so a line stuck
    // high never wraps back below the start threshold.
    always_comb begin
        hi_d = '0;
        if (rxs_q) begin
            hi_d = (hi_q == HI_MAX) ? hi_q : hi_q + 32'd1;
        end
    end

    // A start symbol (H,L) after an idle/stop symbol (L,H) yields a high run
    // of a full baud; idle toggling only gives half a baud.
    assign start_det = !rxs_q && (hi_q >= START_MIN);

    // The first chip lies 3/4 baud after the start mid-edge; every later
    // chip is half a baud after the previous sample.
    assign sample_pt = (ph_q == (first_q ? FIRST_LIM : NEXT_LIM));

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        tmo_d   = tmo_q;
        first_d = first_q;
        chipb_d = chipb_q;
        chipa_d = chipa_q;
        half_d  = half_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        msb_d   = msb_q;
        data_d  = data_q;
        valid_d = valid_q & ~rx_if.rx_ready;
        err_d   = 1'b0;
        ovr_d   = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (start_det) begin
                    state_d = SAMPLE;
                    half_d  = 1'b0;
                    ph_d    = '0;
                    first_d = 1'b1;
                    chipb_d = 1'b0;
                    bits_d  = '0;
                end
            end

            GAP: begin
                tmo_d = tmo_q + 32'd1;
                if (start_det) begin
                    state_d = SAMPLE;
                    half_d  = 1'b1;
                    ph_d    = '0;
                    first_d = 1'b1;
                    chipb_d = 1'b0;
                    bits_d  = '0;
                end else if (tmo_q >= GAP_LIM) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                end
            end

            SAMPLE, STOP: begin
                ph_d = ph_q + 32'd1;
                if (sample_pt) begin
                    ph_d    = '0;
                    first_d = 1'b0;
                    chipb_d = ~chipb_q;
                    if (!chipb_q) begin
                        chipa_d = rxs_q;
                    end else if (state_q == SAMPLE) begin
                        // Equal chips carry no transition: code violation.
                        if (rxs_q == chipa_q) begin
                            err_d   = 1'b1;
                            state_d = HUNT;
                        end else begin
                            shreg_d = {shreg_q[NB-2:0], rxs_q};
                            bits_d  = bits_q + 4'd1;
                            if (bits_q == LAST_BIT) begin
                                state_d = STOP;
                            end
                        end
                    end else begin
                        if (chipa_q || !rxs_q) begin
                            err_d   = 1'b1;
                            state_d = HUNT;
                        end else if (!half_q) begin
                            msb_d   = shreg_q;
                            tmo_d   = '0;
                            state_d = GAP;
                        end else begin
                            state_d = DELIVER;
                        end
                    end
                end
            end

            DELIVER: begin
                // A word accepted this very cycle frees the slot for the
                // new one; otherwise an occupied slot drops the new word.
                if (!valid_q || rx_if.rx_ready) begin
                    data_d  = {msb_q, shreg_q};
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
                state_d = HUNT;
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HUNT;
            sync_q  <= 1'b0;
            rxs_q   <= 1'b0;
            hi_q    <= '0;
            ph_q    <= '0;
            tmo_q   <= '0;
            first_q <= 1'b0;
            chipb_q <= 1'b0;
            chipa_q <= 1'b0;
            half_q  <= 1'b0;
            bits_q  <= '0;
            shreg_q <= '0;
            msb_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= rx;
            rxs_q   <= sync_q;
            hi_q    <= hi_d;
            ph_q    <= ph_d;
            tmo_q   <= tmo_d;
            first_q <= first_d;
            chipb_q <= chipb_d;
            chipa_q <= chipa_d;
            half_q  <= half_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            msb_q   <= msb_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign rx_error       = err_q;
    assign rx_overrun     = ovr_q;

endmodule

// File: tb/tb_manchester_uart_rx.sv
// Directed bench for manchester_uart_rx: drives Manchester chips on rx and
// checks recovered words, error/overrun pulses and reset behaviour.
module tb_manchester_uart_rx;

    localparam int DB = 8;
    localparam int FB = 18_750_000 / 115200;
    localparam int HB = FB / 2;

    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic rx_error;
    logic rx_overrun;

    always #5 clk = ~clk;

    manchester_uart_rx_if #(.DATA_BITS(DB)) rif ();

    manchester_uart_rx #(
        .DATA_BITS(DB),
        .BAUDRATE (115200),
        .CLK_FREQ (18_750_000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_if     (rif.master),
        .rx_error  (rx_error),
        .rx_overrun(rx_overrun)
    );

    int vec  = 0;
    int miss = 0;

    int vrise = 0;
    int vhigh = 0;
    int verr  = 0;
    int vovr  = 0;
    int vboth = 0;
    logic vprev = 1'b0;
    logic [DB-1:0] acc[$];

    always @(negedge clk) begin
        if (rif.rx_valid === 1'b1 && !vprev) vrise++;
        if (rif.rx_valid === 1'b1) vhigh++;
        if (rx_error === 1'b1) verr++;
        if (rx_overrun === 1'b1) vovr++;
        if (rx_error === 1'b1 && rx_overrun === 1'b1) vboth++;
        if (rif.rx_valid === 1'b1 && rif.rx_ready === 1'b1)
            acc.push_back(rif.rx_data);
        vprev = (rif.rx_valid === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chip(input logic v);
        rx = v;
        tick(HB);
    endtask

    task automatic sym(input logic b);
        if (b) begin
            chip(1'b0);
            chip(1'b1);
        end else begin
            chip(1'b1);
            chip(1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sym(1'b1);
    endtask

    task automatic half(input logic [3:0] nib);
        chip(1'b1);
        chip(1'b0);
        for (int i = 3; i >= 0; i--) sym(nib[i]);
        sym(1'b1);
    endtask

    task automatic word(input logic [7:0] w);
        half(w[7:4]);
        half(w[3:0]);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx = 1'b1;
        rif.rx_ready = 1'b1;
        tick(3);
        vec++;
        if (rif.rx_valid !== 1'b0) begin
            miss++;
            $display("FAIL reset_valid got=%b exp=0", rif.rx_valid);
        end
        vec++;
        if (rif.rx_data !== 8'h00) begin
            miss++;
            $display("FAIL reset_data got=%h exp=00", rif.rx_data);
        end
        vec++;
        if (rx_error !== 1'b0 || rx_overrun !== 1'b0) begin
            miss++;
            $display("FAIL reset_pulses got=%b%b exp=00", rx_error, rx_overrun);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic;
        int r0, h0, e0;
        acc.delete();
        rif.rx_ready = 1'b1;
        idle(20);
        r0 = vrise;
        h0 = vhigh;
        e0 = verr;
        word(8'hA5);
        vec++;
        if (vrise - r0 !== 1) begin
            miss++;
            $display("FAIL basic_valid_rise got=%0d exp=1", vrise - r0);
        end
        idle(2);
        vec++;
        if (vhigh - h0 !== 1) begin
            miss++;
            $display("FAIL basic_valid_cycles got=%0d exp=1", vhigh - h0);
        end
        vec++;
        if (acc.size() !== 1 || acc[0] !== 8'hA5) begin
            miss++;
            $display("FAIL basic_data got_n=%0d exp=1 word a5", acc.size());
        end
        vec++;
        if (verr - e0 !== 0) begin
            miss++;
            $display("FAIL basic_error got=%0d exp=0", verr - e0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_w[3];
        exp_w[0] = 8'h00;
        exp_w[1] = 8'hFF;
        exp_w[2] = 8'h3C;
        acc.delete();
        rif.rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) word(exp_w[i]);
        idle(2);
        vec++;
        if (acc.size() !== 3) begin
            miss++;
            $display("FAIL b2b_count got=%0d exp=3", acc.size());
        end
        for (int i = 0; i < 3; i++) begin
            vec++;
            if (acc.size() > i && acc[i] !== exp_w[i]) begin
                miss++;
                $display("FAIL b2b_word%0d got=%h exp=%h", i, acc[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_violation;
        int r0, e0;
        acc.delete();
        rif.rx_ready = 1'b1;
        idle(4);
        r0 = vrise;
        e0 = verr;
        chip(1'b1);
        chip(1'b0);
        sym(1'b0);
        chip(1'b1);
        chip(1'b1);
        vec++;
        if (verr - e0 !== 1) begin
            miss++;
            $display("FAIL viol_error got=%0d exp=1", verr - e0);
        end
        sym(1'b0);
        sym(1'b1);
        sym(1'b1);
        half(4'hA);
        idle(20);
        vec++;
        if (vrise - r0 !== 0) begin
            miss++;
            $display("FAIL viol_no_valid got=%0d exp=0", vrise - r0);
        end
        word(8'h81);
        idle(2);
        vec++;
        if (acc.size() !== 1 || acc[0] !== 8'h81) begin
            miss++;
            $display("FAIL viol_recover got_n=%0d exp=1 word 81", acc.size());
        end
    endtask

    task automatic test_overrun;
        int o0, r0;
        rif.rx_ready = 1'b0;
        idle(2);
        o0 = vovr;
        r0 = vrise;
        word(8'h11);
        word(8'h22);
        idle(2);
        vec++;
        if (rif.rx_valid !== 1'b1 || rif.rx_data !== 8'h11) begin
            miss++;
            $display("FAIL ovr_hold got=%b/%h exp=1/11", rif.rx_valid, rif.rx_data);
        end
        vec++;
        if (vovr - o0 !== 1) begin
            miss++;
            $display("FAIL ovr_pulses got=%0d exp=1", vovr - o0);
        end
        vec++;
        if (vrise - r0 !== 1) begin
            miss++;
            $display("FAIL ovr_rise got=%0d exp=1", vrise - r0);
        end
        rif.rx_ready = 1'b1;
        tick(1);
        vec++;
        if (rif.rx_valid !== 1'b0 || rif.rx_data !== 8'h11) begin
            miss++;
            $display("FAIL ovr_accept got=%b/%h exp=0/11", rif.rx_valid, rif.rx_data);
        end
    endtask

    task automatic test_timeout;
        int e0, r0;
        rif.rx_ready = 1'b1;
        idle(4);
        e0 = verr;
        r0 = vrise;
        half(4'h7);
        idle(3);
        vec++;
        if (verr - e0 !== 0) begin
            miss++;
            $display("FAIL tmo_early got=%0d exp=0", verr - e0);
        end
        idle(2);
        vec++;
        if (verr - e0 !== 1) begin
            miss++;
            $display("FAIL tmo_error got=%0d exp=1", verr - e0);
        end
        vec++;
        if (vrise - r0 !== 0) begin
            miss++;
            $display("FAIL tmo_no_valid got=%0d exp=0", vrise - r0);
        end
    endtask

    task automatic test_reset_midframe;
        int e0, r0;
        rif.rx_ready = 1'b1;
        idle(4);
        half(4'hC);
        chip(1'b1);
        chip(1'b0);
        sym(1'b0);
        e0 = verr;
        r0 = vrise;
        reset = 1'b1;
        tick(1);
        vec++;
        if (rif.rx_data !== 8'h00 || rif.rx_valid !== 1'b0) begin
            miss++;
            $display("FAIL rstmid_out got=%h/%b exp=00/0", rif.rx_data, rif.rx_valid);
        end
        vec++;
        if (rx_error !== 1'b0 || rx_overrun !== 1'b0) begin
            miss++;
            $display("FAIL rstmid_pulses got=%b%b exp=00", rx_error, rx_overrun);
        end
        reset = 1'b0;
        sym(1'b0);
        sym(1'b1);
        sym(1'b1);
        sym(1'b1);
        idle(4);
        vec++;
        if (verr - e0 !== 0 || vrise - r0 !== 0) begin
            miss++;
            $display("FAIL rstmid_quiet got=%0d/%0d exp=0/0", verr - e0, vrise - r0);
        end
        acc.delete();
        word(8'h96);
        idle(2);
        vec++;
        if (acc.size() !== 1 || acc[0] !== 8'h96) begin
            miss++;
            $display("FAIL rstmid_recover got_n=%0d exp=1 word 96", acc.size());
        end
    endtask

    task automatic test_glitch;
        int e0, r0;
        e0 = verr;
        r0 = vrise;
        rx = 1'b0;
        tick(200);
        rx = 1'b1;
        tick(60);
        rx = 1'b0;
        tick(300);
        idle(6);
        vec++;
        if (verr - e0 !== 0) begin
            miss++;
            $display("FAIL glitch_error got=%0d exp=0", verr - e0);
        end
        vec++;
        if (vrise - r0 !== 0) begin
            miss++;
            $display("FAIL glitch_valid got=%0d exp=0", vrise - r0);
        end
    endtask

    task automatic test_exclusive;
        vec++;
        if (vboth !== 0) begin
            miss++;
            $display("FAIL err_ovr_overlap got=%0d exp=0", vboth);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_violation();
        test_overrun();
        test_timeout();
        test_reset_midframe();
        test_glitch();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
